branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 138 +++++++++++++
 tb/tb_branch_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller for the ID stage: stalls on unready operands and
// defers redirects while the pipeline is frozen. Optional stats counters via BRANCH_CTRL_STATS_EN.
module branch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  input  logic [2:0]  br_type,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic        eq,
  input  logic        eqz,
  input  logic        ltz,
  input  logic        gtz,
  input  logic [31:0] br_target,
  input  logic        ext_stall,
  output logic        br_stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [15:0] stall_cycles,
  output logic [15:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;

  state_t      state_q, state_d;
  logic        taken_q, taken_d;
  logic [31:0] tgt_q, tgt_d;

  logic is_br;
  logic ready;
  logic taken;

  always_comb begin
    is_br = (br_type != 3'd0) && (br_type != 3'd7);
    ready = rs_ready && (((br_type != BR_BEQ) && (br_type != BR_BNE)) || rt_ready);
    unique case (br_type)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BLEZ: taken = ltz | eqz;
      BR_BGTZ: taken = gtz;
      BR_BLTZ: taken = ltz;
      BR_BGEZ: taken = gtz | eqz;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      taken_q <= 1'b0;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    taken_d     = taken_q;
    tgt_d       = tgt_q;
    br_stall    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    unique case (state_q)
      IDLE, WAIT: begin
        if (!br_valid || !is_br) begin
          state_d = IDLE;
        end else if (!ready) begin
          br_stall = 1'b1;
          state_d  = WAIT;
        end else if (ext_stall) begin
          // Resolve now but hold the outcome until the pipeline unfreezes.
          taken_d = taken;
          tgt_d   = br_target;
          state_d = HOLD;
        end else begin
          redirect    = taken;
          redirect_pc = taken ? br_target : 32'd0;
          state_d     = IDLE;
        end
      end
      HOLD: begin
        if (!br_valid) begin
          state_d = IDLE;
        end else if (!ext_stall) begin
          redirect    = taken_q;
          redirect_pc = taken_q ? tgt_q : 32'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      br_stall    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    taken_cnt_d    = taken_cnt_q;
    if (br_stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
    if (redirect && (taken_cnt_q != 16'hFFFF))    taken_cnt_d    = taken_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 16'd0;
      taken_cnt_q    <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      taken_cnt_q    <= taken_cnt_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign taken_cnt    = taken_cnt_q;
`else
  assign stall_cycles = 16'd0;
  assign taken_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl; counter expectations follow BRANCH_CTRL_STATS_EN.
module tb_branch_ctrl;

`ifdef BRANCH_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [2:0]  br_type;
  logic        rs_ready, rt_ready;
  logic        eq, eqz, ltz, gtz;
  logic [31:0] br_target;
  logic        ext_stall;
  logic        br_stall, redirect;
  logic [31:0] redirect_pc;
  logic [15:0] stall_cycles, taken_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .eq(eq), .eqz(eqz), .ltz(ltz), .gtz(gtz),
    .br_target(br_target), .ext_stall(ext_stall), .br_stall(br_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall_cycles(stall_cycles), .taken_cnt(taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic rs, input logic rt,
                       input logic e, input logic ez, input logic lz, input logic gz,
                       input logic [31:0] tgt, input logic ext);
    br_valid = v; br_type = t; rs_ready = rs; rt_ready = rt;
    eq = e; eqz = ez; ltz = lz; gtz = gz; br_target = tgt; ext_stall = ext;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic outs(input string tag, input logic s, input logic r, input logic [31:0] pc);
    #1;
    check({tag, ".stall"}, {31'd0, br_stall}, {31'd0, s});
    check({tag, ".redir"}, {31'd0, redirect}, {31'd0, r});
    check({tag, ".pc"}, redirect_pc, pc);
  endtask

  task automatic do_reset();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 32'd0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 3'd1, 1, 1, 1, 0, 0, 0, 32'h0000_3010, 0);
    step();
    outs("rst_force", 0, 0, 32'd0);
    step();
    check("rst_stallcnt", {16'd0, stall_cycles}, 32'd0);
    check("rst_takencnt", {16'd0, taken_cnt}, 32'd0);
    reset = 1'b0;
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 32'd0, 0);
    step();

    // BEQ taken and not taken, zero-cycle resolution
    drive(1, 3'd1, 1, 1, 1, 0, 0, 0, 32'h0000_3010, 0);
    outs("beq_taken", 0, 1, 32'h0000_3010);
    step();
    drive(1, 3'd1, 1, 1, 0, 0, 0, 0, 32'h0000_3010, 0);
    outs("beq_ntaken", 0, 0, 32'd0);
    step();
    drive(1, 3'd7, 1, 1, 1, 1, 1, 1, 32'h0000_5555, 0);
    outs("reserved", 0, 0, 32'd0);
    step();

    // BNE waits 3 cycles on rt
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd2, 1, 0, 0, 0, 0, 0, 32'h0000_2000, 0);
      outs($sformatf("bne_wait%0d", i), 1, 0, 32'd0);
      step();
    end
    drive(1, 3'd2, 1, 1, 0, 0, 0, 0, 32'h0000_2000, 0);
    outs("bne_go", 0, 1, 32'h0000_2000);
    step();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 32'd0, 0);
    outs("bne_after", 0, 0, 32'd0);
    check("bne_stallcnt", {16'd0, stall_cycles}, STATS ? 32'd3 : 32'd0);
    check("bne_takencnt", {16'd0, taken_cnt}, STATS ? 32'd1 : 32'd0);
    step();

    // BGEZ ignores rt_ready; BGTZ with gtz=0 is not taken
    drive(1, 3'd6, 1, 0, 0, 1, 0, 0, 32'h0000_4000, 0);
    outs("bgez", 0, 1, 32'h0000_4000);
    step();
    drive(1, 3'd4, 1, 0, 0, 1, 0, 0, 32'h0000_4000, 0);
    outs("bgtz_nt", 0, 0, 32'd0);
    step();
    drive(1, 3'd3, 0, 1, 0, 1, 0, 0, 32'h0000_4000, 0);
    outs("blez_rsw", 1, 0, 32'd0);
    step();
    drive(1, 3'd3, 1, 0, 0, 1, 0, 0, 32'h0000_4100, 0);
    outs("blez_go", 0, 1, 32'h0000_4100);
    step();

    // BLTZ resolved under ext_stall, inputs scrambled during HOLD
    drive(1, 3'd5, 1, 1, 0, 0, 1, 0, 32'h0000_3400, 1);
    outs("bltz_hold0", 0, 0, 32'd0);
    step();
    for (int i = 1; i < 4; i++) begin
      drive(1, 3'd5, 0, 0, 1, 1, 0, 1, 32'hDEAD_BEEF, 1);
      outs($sformatf("bltz_hold%0d", i), 0, 0, 32'd0);
      step();
    end
    drive(1, 3'd5, 0, 0, 1, 1, 0, 1, 32'hDEAD_BEEF, 0);
    outs("bltz_rel", 0, 1, 32'h0000_3400);
    step();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 32'd0, 0);
    outs("bltz_after", 0, 0, 32'd0);
    step();

    // Abort from WAIT
    drive(1, 3'd2, 1, 0, 0, 0, 0, 0, 32'h0000_6000, 0);
    outs("abort_wait", 1, 0, 32'd0);
    step();
    drive(0, 3'd2, 1, 1, 0, 0, 0, 0, 32'h0000_6000, 0);
    outs("abort_cyc", 0, 0, 32'd0);
    step();
    drive(1, 3'd0, 1, 1, 0, 0, 0, 0, 32'h0000_6000, 0);
    outs("abort_idle", 0, 0, 32'd0);
    step();

    // Reset while in HOLD drops the pending redirect
    drive(1, 3'd5, 1, 1, 0, 0, 1, 0, 32'h0000_7000, 1);
    outs("rsth_enter", 0, 0, 32'd0);
    step();
    reset = 1'b1;
    drive(1, 3'd5, 1, 1, 0, 0, 1, 0, 32'h0000_7000, 0);
    outs("rsth_force", 0, 0, 32'd0);
    step();
    reset = 1'b0;
    drive(1, 3'd0, 0, 0, 0, 0, 0, 0, 32'h0000_7000, 0);
    outs("rsth_after", 0, 0, 32'd0);
    check("rsth_stallcnt", {16'd0, stall_cycles}, 32'd0);
    check("rsth_takencnt", {16'd0, taken_cnt}, 32'd0);
    step();

    // 70000 stall cycles saturate the counter
    do_reset();
    drive(1, 3'd1, 1, 0, 0, 0, 0, 0, 32'h0000_8000, 0);
    outs("sat_first", 1, 0, 32'd0);
    for (int i = 0; i < 70000; i++) step();
    outs("sat_last", 1, 0, 32'd0);
    check("sat_stallcnt", {16'd0, stall_cycles}, STATS ? 32'h0000_FFFF : 32'd0);
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 32'd0, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
